wshb_arbiter: RTL and testbench

//  Two-master, one-slave Wishbone classic arbiter in the system clock domain.
//  It shares the SDRAM slave port between M0 (video frame reader, read-only stream) and M1 (frame writer/CPU).

---
 rtl/wshb_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_wshb_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/wshb_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter.
// M0 (video frame reader) and M1 (frame writer / CPU) share the SDRAM slave.
// Grants are round-robin and are held for the whole bus cycle (cyc high).
// A watchdog aborts the owner's cycle if the slave never answers.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | no owner; slave request lines quiet; arbitrate pending requests
// OWN0  | M0 owns the slave port until it drops m0_cyc (or watchdog fires)
// OWN1  | M1 owns the slave port until it drops m1_cyc (or watchdog fires)
// ABORT | one quiet cycle after a watchdog abort; arbitrates like IDLE
module wshb_arbiter #(
  parameter int TIMEOUT = 256,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [3:0]    m0_sel,
  input  logic [31:0]   m0_dat_ms,
  input  logic [2:0]    m0_cti,
  input  logic [1:0]    m0_bte,
  output logic          m0_ack,
  output logic          m0_err,
  output logic [31:0]   m0_dat_sm,

  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [3:0]    m1_sel,
  input  logic [31:0]   m1_dat_ms,
  input  logic [2:0]    m1_cti,
  input  logic [1:0]    m1_bte,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [31:0]   m1_dat_sm,

  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [AW-1:0] s_adr,
  output logic [3:0]    s_sel,
  output logic [31:0]   s_dat_ms,
  output logic [2:0]    s_cti,
  output logic [1:0]    s_bte,
  input  logic          s_ack,
  input  logic          s_err,
  input  logic [31:0]   s_dat_sm
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    ABORT = 2'd3
  } state_t;

  // A zero TIMEOUT still needs a legal (1-bit) counter even though it never fires.
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit WD_ENABLE = (TIMEOUT > 0);

  state_t         state;
  state_t         state_nxt;
  logic           last;
  logic           last_nxt;
  logic [WDW-1:0] wdog;
  logic [WDW-1:0] wdog_nxt;

  logic           own_stb;
  logic           wd_count;
  logic           wd_fire;
  state_t         arb_pick;

  // Round-robin pick among current requests; last=1 means M1 was served most recently.
  always_comb begin
    arb_pick = IDLE;
    if (m0_cyc && m1_cyc) begin
      arb_pick = last ? OWN0 : OWN1;
    end else if (m0_cyc) begin
      arb_pick = OWN0;
    end else if (m1_cyc) begin
      arb_pick = OWN1;
    end
  end

  // Watchdog qualifier: owner strobing with no slave response this cycle.
  always_comb begin
    own_stb = 1'b0;
    case (state)
      OWN0:    own_stb = m0_stb;
      OWN1:    own_stb = m1_stb;
      default: own_stb = 1'b0;
    endcase
    wd_count = own_stb && !s_ack && !s_err;
    wd_fire  = WD_ENABLE && wd_count && (wdog == WD_LAST);
  end

  // Next-state: owners keep the bus while cyc is high; otherwise re-arbitrate.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ABORT: state_nxt = arb_pick;
      OWN0: begin
        if (wd_fire) begin
          state_nxt = ABORT;
        end else if (!m0_cyc) begin
          state_nxt = arb_pick;
        end
      end
      OWN1: begin
        if (wd_fire) begin
          state_nxt = ABORT;
        end else if (!m1_cyc) begin
          state_nxt = arb_pick;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Round-robin pointer remembers whichever master most recently took ownership.
  always_comb begin
    last_nxt = last;
    if (state_nxt != state) begin
      if (state_nxt == OWN0) begin
        last_nxt = 1'b0;
      end else if (state_nxt == OWN1) begin
        last_nxt = 1'b1;
      end
    end
  end

  // Watchdog counts consecutive stalled strobes; any response, idle strobe or handover restarts it.
  always_comb begin
    if (wd_fire || !wd_count || (state_nxt != state)) begin
      wdog_nxt = '0;
    end else begin
      wdog_nxt = wdog + 1'b1;
    end
  end

  // State, round-robin pointer and watchdog registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      wdog  <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      wdog  <= wdog_nxt;
    end
  end

  // Slave request mux and response routing; everything held quiet while in reset.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_sel    = '0;
    s_dat_ms = '0;
    s_cti    = '0;
    s_bte    = '0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    if (!rst) begin
      case (state)
        OWN0: begin
          s_cyc    = m0_cyc;
          s_stb    = m0_stb;
          s_we     = m0_we;
          s_adr    = m0_adr;
          s_sel    = m0_sel;
          s_dat_ms = m0_dat_ms;
          s_cti    = m0_cti;
          s_bte    = m0_bte;
          m0_ack   = s_ack;
          m0_err   = s_err | wd_fire;
        end
        OWN1: begin
          s_cyc    = m1_cyc;
          s_stb    = m1_stb;
          s_we     = m1_we;
          s_adr    = m1_adr;
          s_sel    = m1_sel;
          s_dat_ms = m1_dat_ms;
          s_cti    = m1_cti;
          s_bte    = m1_bte;
          m1_ack   = s_ack;
          m1_err   = s_err | wd_fire;
        end
        default: begin
          // IDLE / ABORT: late slave responses are dropped here.
        end
      endcase
    end
  end

  // Read data is broadcast; each master qualifies it with its own ack.
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed bench for wshb_arbiter (TIMEOUT=8 so the watchdog is reachable).
module tb_wshb_arbiter;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_cyc, m0_stb, m0_we;
  logic [AW-1:0] m0_adr;
  logic [3:0]    m0_sel;
  logic [31:0]   m0_dat_ms;
  logic [2:0]    m0_cti;
  logic [1:0]    m0_bte;
  logic          m0_ack, m0_err;
  logic [31:0]   m0_dat_sm;
  logic          m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m1_adr;
  logic [3:0]    m1_sel;
  logic [31:0]   m1_dat_ms;
  logic [2:0]    m1_cti;
  logic [1:0]    m1_bte;
  logic          m1_ack, m1_err;
  logic [31:0]   m1_dat_sm;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [3:0]    s_sel;
  logic [31:0]   s_dat_ms;
  logic [2:0]    s_cti;
  logic [1:0]    s_bte;
  logic          s_ack, s_err;
  logic [31:0]   s_dat_sm;

  int checks   = 0;
  int failures = 0;
  int n0       = 0;
  int n1       = 0;

  always #5 clk = ~clk;

  wshb_arbiter #(.TIMEOUT(8), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_sel(m0_sel), .m0_dat_ms(m0_dat_ms), .m0_cti(m0_cti), .m0_bte(m0_bte),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_dat_sm(m0_dat_sm),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_sel(m1_sel), .m1_dat_ms(m1_dat_ms), .m1_cti(m1_cti), .m1_bte(m1_bte),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_dat_sm(m1_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_sel(s_sel), .s_dat_ms(s_dat_ms), .s_cti(s_cti), .s_bte(s_bte),
    .s_ack(s_ack), .s_err(s_err), .s_dat_sm(s_dat_sm)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic no_resp(input string tag);
    chk({tag, "_m0_ack"}, {31'd0, m0_ack}, 32'd0);
    chk({tag, "_m1_ack"}, {31'd0, m1_ack}, 32'd0);
    chk({tag, "_m0_err"}, {31'd0, m0_err}, 32'd0);
    chk({tag, "_m1_err"}, {31'd0, m1_err}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h1111_0000;
    m0_sel = 4'hF; m0_dat_ms = 32'hAAAA_0000; m0_cti = 3'b000; m0_bte = 2'b00;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b1; m1_adr = 32'h0000_0200;
    m1_sel = 4'h3; m1_dat_ms = 32'hCAFE_F00D; m1_cti = 3'b010; m1_bte = 2'b01;
    s_ack = 1'b1; s_err = 1'b0; s_dat_sm = 32'h1234_5678;

    // Reset held with a request present: slave side and responses stay quiet.
    #1;
    chk("rst_s_cyc", {31'd0, s_cyc}, 32'd0);
    chk("rst_s_adr", s_adr, 32'd0);
    chk("rst_s_dat_ms", s_dat_ms, 32'd0);
    no_resp("rst");
    next_cycle();
    chk("rst2_s_cyc", {31'd0, s_cyc}, 32'd0);
    chk("rst2_m0_ack", {31'd0, m0_ack}, 32'd0);

    // Ten idle cycles; stray slave ack/err must not reach anyone.
    rst = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_ack = i[0]; s_err = i[1];
      #1;
      chk("idle_s_cyc", {31'd0, s_cyc}, 32'd0);
      no_resp("idle");
      next_cycle();
    end
    s_ack = 1'b0; s_err = 1'b0;

    // Simultaneous request: M0 wins the first tie, one cycle later.
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_0100;
    m1_cyc = 1'b1; m1_stb = 1'b1;
    #1;
    chk("arb_latency_s_cyc", {31'd0, s_cyc}, 32'd0);
    next_cycle();
    s_ack = 1'b1;
    #1;
    chk("own0_s_cyc", {31'd0, s_cyc}, 32'd1);
    chk("own0_s_adr", s_adr, 32'h0000_0100);
    chk("own0_s_we", {31'd0, s_we}, 32'd0);
    chk("own0_m0_ack", {31'd0, m0_ack}, 32'd1);
    chk("own0_m1_ack", {31'd0, m1_ack}, 32'd0);
    next_cycle();
    m0_adr = 32'h0000_0104;
    #1;
    chk("own0_s_adr2", s_adr, 32'h0000_0104);
    chk("own0_m0_ack2", {31'd0, m0_ack}, 32'd1);
    next_cycle();
    #1;
    chk("own0_m0_ack3", {31'd0, m0_ack}, 32'd1);
    next_cycle();
    m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
    #1;
    chk("own0_drop_s_cyc", {31'd0, s_cyc}, 32'd0);
    next_cycle();
    s_ack = 1'b1;
    #1;
    chk("hand_s_cyc", {31'd0, s_cyc}, 32'd1);
    chk("hand_s_adr", s_adr, 32'h0000_0200);
    chk("hand_s_we", {31'd0, s_we}, 32'd1);
    chk("hand_s_sel", {28'd0, s_sel}, 32'h3);
    chk("hand_s_dat_ms", s_dat_ms, 32'hCAFE_F00D);
    chk("hand_s_cti", {29'd0, s_cti}, 32'd2);
    chk("hand_s_bte", {30'd0, s_bte}, 32'd1);
    chk("hand_m1_ack", {31'd0, m1_ack}, 32'd1);
    chk("hand_m0_ack", {31'd0, m0_ack}, 32'd0);
    chk("hand_m0_dat_sm", m0_dat_sm, 32'h1234_5678);
    chk("hand_m1_dat_sm", m1_dat_sm, 32'h1234_5678);
    next_cycle();
    m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
    next_cycle();

    // Alternation: both request; each owner drops cyc for one cycle after its ack.
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    #1;
    chk("rr_pre_s_cyc", {31'd0, s_cyc}, 32'd0);
    next_cycle();
    for (int i = 0; i < 100; i++) begin
      m0_cyc = 1'b1; m1_cyc = 1'b1; s_ack = 1'b1;
      #1;
      chk("rr_m0_ack", {31'd0, m0_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_m1_ack", {31'd0, m1_ack}, (i % 2 == 1) ? 32'd1 : 32'd0);
      n0 += int'(m0_ack);
      n1 += int'(m1_ack);
      next_cycle();
      if (i % 2 == 0) m0_cyc = 1'b0; else m1_cyc = 1'b0;
      s_ack = 1'b0;
      next_cycle();
    end
    chk("rr_n0", n0, 32'd50);
    chk("rr_n1", n1, 32'd50);
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    next_cycle();

    // M1 owns with strobe low while M0 waits: grant kept, no watchdog.
    m1_cyc = 1'b1; m1_stb = 1'b0;
    next_cycle();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      chk("hold_s_cyc", {31'd0, s_cyc}, 32'd1);
      chk("hold_s_adr", s_adr, 32'h0000_0200);
      chk("hold_m1_err", {31'd0, m1_err}, 32'd0);
      chk("hold_m0_ack", {31'd0, m0_ack}, 32'd0);
      next_cycle();
    end

    // M1 leaves; M0 stalls forever -> watchdog error on 8th stalled cycle.
    m1_cyc = 1'b0;
    next_cycle();
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h0000_0300;
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk("wd_s_adr", s_adr, 32'h0000_0104);
      chk("wd_m0_err", {31'd0, m0_err}, (k == 8) ? 32'd1 : 32'd0);
      next_cycle();
    end
    s_ack = 1'b1;
    #1;
    chk("abort_s_cyc", {31'd0, s_cyc}, 32'd0);
    no_resp("abort");
    next_cycle();
    s_ack = 1'b0;
    #1;
    chk("after_abort_s_cyc", {31'd0, s_cyc}, 32'd1);
    chk("after_abort_s_adr", s_adr, 32'h0000_0300);

    // Reset mid-transfer, then both requesting: M0 must win.
    rst = 1'b1;
    #1;
    chk("midrst_s_cyc", {31'd0, s_cyc}, 32'd0);
    next_cycle();
    rst = 1'b0;
    #1;
    chk("postrst_s_cyc", {31'd0, s_cyc}, 32'd0);
    next_cycle();
    s_ack = 1'b1;
    #1;
    chk("postrst_s_adr", s_adr, 32'h0000_0104);
    chk("postrst_m0_ack", {31'd0, m0_ack}, 32'd1);
    chk("postrst_m1_ack", {31'd0, m1_ack}, 32'd0);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
